uart_tx_arb: RTL
================

// Module: uart_tx_arb
// PURPOSE
//  Shares the single UART_tx byte transmitter among NREQ on-board requesters
//  (auth ack/status, telemetry, battery report, debug).
//  Each requester presents a byte plus a level request. The arbiter picks a winner
//  round-robin, loads UART_tx, and waits for tx_done. It then enforces an
//  inter-byte gap before granting the next byte.
//  A watchdog recovers from a lost tx_done.
//  Sits between requester blocks and UART_tx, mirroring UART_rcv on the RX side.
// PARAMETERS
//  NREQ       4     number of requesters (2..8)
//  GAP_CLKS   16    idle clocks between tx_done and next arbitration (0 = none)
//  TO_CLKS    65536 max clocks in WAIT_DONE before timeout (>= 2 UART frames)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous, active-low reset
//  en         in   1        arbitration enable (tie to pwr_up or 1)
//  req        in   NREQ     level request per requester; held until gnt
//  req_data   in   8*NREQ   flat byte bus; requester i drives [8*i+7:8*i]
//  gnt        out  NREQ     one-hot, one-cycle pulse: byte i accepted
//  trmt       out  1        one-cycle start strobe to UART_tx
//  tx_data    out  8        byte to UART_tx; held stable until next load
//  tx_done    in   1        one-cycle pulse from UART_tx: frame finished
//  busy       out  1        high in any state other than IDLE
//  to_err     out  1        sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, trmt=0, tx_data=8'h00, busy=0, to_err=0.
//   Last-grant pointer resets to NREQ-1, so req[0] has top priority first.
//  FSM (all outputs registered):
//   IDLE: if en && |req, winner w = first set bit scanning upward from
//     last+1, wrapping at NREQ. Next cycle: gnt[w]=1, trmt=1,
//     tx_data=req_data[w], last=w -> WAIT_DONE.
//   WAIT_DONE: timer counts up.
//     On tx_done: go to GAP if GAP_CLKS>0, else IDLE.
//     If timer reaches TO_CLKS-1 with no tx_done: to_err=1 -> IDLE.
//   GAP: count GAP_CLKS clocks -> IDLE. Requests are ignored in GAP.
//  Latency: req sampled in IDLE at cycle N -> gnt/trmt high at N+1.
//   Minimum byte-to-byte spacing = frame time + GAP_CLKS + 1.
//  Handshake rules:
//   - Requester i deasserts req or changes data in the cycle after gnt[i].
//   - A req still high after gnt is re-arbitrated as a new byte. Rotation
//     guarantees each other active requester one byte first.
//   - If req drops before it is granted, no grant occurs and nothing is sent.
//  Boundaries:
//   - en low in IDLE: no arbitration. en falling mid-transfer: the current
//     byte completes normally.
//   - tx_done in IDLE or GAP: ignored.
//   - tx_done on the same cycle the timer expires: treat as done; to_err
//     is not set.
//   - Only one requester: it is granted every arbitration; spacing is
//     still enforced.
//   - Pointer wrap: last=NREQ-1 scans from 0.
//   - Asynchronous reset mid-transfer: immediate return to reset values.
//     A frame already in flight in UART_tx is not aborted by this block.
//   - Timer width = $clog2(TO_CLKS). Gap counter width = $clog2(GAP_CLKS+1).
//     Both saturate and never wrap.
// STRUCTURE
//  Package uart_arb_pkg: typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP}
//   arb_state_t; localparam BYTE_W = 8.
//  Sub-module rr_pick #(N): combinational round-robin picker.
//   Inputs req[N-1:0] and last[$clog2(N)-1:0]; outputs any and onehot[N-1:0].
//   Implemented as a double-width rotate-and-priority-encode.
//  Top level holds the FSM, pointer, data mux/register, timer and gap counter.
// TESTING
//  1 Reset, then req=4'b1111 held continuously -> grants in order
//    0,1,2,3,0. tx_data matches each byte (e.g. 8'h67,8'h73,8'hA5,8'h3C).
//  2 req=4'b0100 only -> gnt=4'b0100 one cycle after req, with trmt=1.
//    Next trmt no earlier than tx_done + GAP_CLKS + 1 clocks.
//  3 Hold tx_done low -> after TO_CLKS cycles to_err=1, busy=0.
//    Arbitration then resumes; to_err stays 1.
//  4 en=0 with req=4'b0011 -> no gnt/trmt for 100 clks.
//    Drop en during WAIT_DONE -> tx_done still returns FSM to GAP/IDLE.
//  5 req[1] pulses high then low before its turn while req[0] is busy
//    -> gnt[1] never asserts, and no byte 8'hXX is sent.
//  6 Assert rst_n low during WAIT_DONE -> all outputs 0 at once.
//    After release, req=4'b1010 is granted 1 first (pointer reset to 3).

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_t : arbiter FSM state encoding
//   BYTE_W      : width of one transmitted byte
//   cnt_w()     : counter width helper that never returns zero
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } arb_state_t;

  // $clog2 of 1 is 0, which would give a zero-width counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle between the requester blocks, the arbiter and UART_tx.
//   en        : arbitration enable
//   req       : level request per requester
//   req_data  : flat byte bus, requester i on [8*i+7:8*i]
//   gnt       : one-hot grant pulse
//   trmt      : start strobe to UART_tx
//   tx_data   : byte to UART_tx
//   tx_done   : frame-finished pulse from UART_tx
//   busy      : arbiter not idle
//   to_err    : sticky lost-tx_done flag
// master = arbiter side, slave = requester/UART side.
interface uart_tx_arb_if #(
  parameter int NREQ = 4
) ();
  import uart_arb_pkg::*;

  logic                     en;
  logic [NREQ-1:0]          req;
  logic [BYTE_W*NREQ-1:0]   req_data;
  logic [NREQ-1:0]          gnt;
  logic                     trmt;
  logic [BYTE_W-1:0]        tx_data;
  logic                     tx_done;
  logic                     busy;
  logic                     to_err;

  modport master (
    input  en, req, req_data, tx_done,
    output gnt, trmt, tx_data, busy, to_err
  );

  modport slave (
    output en, req, req_data, tx_done,
    input  gnt, trmt, tx_data, busy, to_err
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   last   : index of the previous winner
//   any    : at least one request is set
//   onehot : winner, first set bit scanning upward from last+1 with wrap
// The request vector is rotated so that last+1 lands at bit 0, the lowest
// set bit is isolated, and the result is rotated back.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 any,
  output logic [N-1:0]         onehot
);

  localparam int             LW       = $clog2(N);
  localparam logic [LW-1:0]  LAST_IDX = LW'(N - 1);

  logic [LW-1:0] start;
  logic [N-1:0]  rot;
  logic [N-1:0]  pick_rot;

  always_comb begin
    start    = (last == LAST_IDX) ? '0 : last + LW'(1);
    rot      = N'({req, req} >> start);
    // two's-complement trick keeps only the lowest set bit
    pick_rot = rot & (~rot + N'(1));
    onehot   = N'(({pick_rot, pick_rot} << start) >> N);
    any      = |req;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares the single UART_tx byte transmitter among NREQ requesters.
// A round-robin winner is loaded into UART_tx, the arbiter waits for
// tx_done (with a watchdog), then holds off for GAP_CLKS clocks.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   bus      : uart_tx_arb_if.master (requests, grants, UART_tx strobe/data,
//              busy and sticky timeout flag)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for en && any request; arbitrates and loads UART_tx
// WAIT_DONE | byte in flight; watchdog timer running until tx_done
// GAP       | enforced idle spacing after tx_done; requests ignored
module uart_tx_arb #(
  parameter int NREQ     = 4,
  parameter int GAP_CLKS = 16,
  parameter int TO_CLKS  = 65536
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_arb_if.master  bus
);
  import uart_arb_pkg::*;

  localparam int LW = $clog2(NREQ);
  localparam int TW = cnt_w(TO_CLKS);
  localparam int GW = cnt_w(GAP_CLKS + 1);

  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CLKS > 0) ? GW'(GAP_CLKS - 1) : GW'(0);

  arb_state_t        state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              trmt_q, trmt_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              to_err_q, to_err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic              pick_any;
  logic [NREQ-1:0]   pick_oh;
  logic [LW-1:0]     pick_idx;
  logic [BYTE_W-1:0] pick_data;

  rr_pick #(.N(NREQ)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .any    (pick_any),
    .onehot (pick_oh)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx  = LW'(i);
        pick_data = bus.req_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = '0;
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    to_err_d  = to_err_q;
    timer_d   = timer_q;
    gap_d     = gap_q;

    case (state_q)
      IDLE: begin
        if (bus.en && pick_any) begin
          gnt_d     = pick_oh;
          trmt_d    = 1'b1;
          tx_data_d = pick_data;
          last_d    = pick_idx;
          timer_d   = '0;
          state_d   = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // tx_done wins over a coincident watchdog expiry
        if (bus.tx_done) begin
          gap_d   = '0;
          state_d = (GAP_CLKS > 0) ? GAP : IDLE;
        end else if (timer_q == TO_LAST) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= LW'(NREQ - 1);
      gnt_q     <= '0;
      trmt_q    <= 1'b0;
      tx_data_q <= '0;
      to_err_q  <= 1'b0;
      timer_q   <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
      to_err_q  <= to_err_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.trmt    = trmt_q;
  assign bus.tx_data = tx_data_q;
  assign bus.to_err  = to_err_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
